rv32i_instr_encoder: RTL and testbench

Streaming RV32I instruction encoder: accepts decoded instruction fields (format, opcode, register addresses, funct3/funct7, immediate) over a valid/ready handshake and emits the packed 32-bit instruction word with a sequential instruction-memory byte address. It is the inverse of the MCU decoder and sits between the debug/bootloader loader and the instruction-memory write port. Every legal field set it emits decodes back to the same fields. Illegal field sets are dropped and flagged.

---
 rtl/rv32i_instr_encoder_if.sv | 35 +++
 rtl/rv32i_instr_encoder.sv | 123 ++++++++++++
 tb/tb_rv32i_instr_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_instr_encoder_if.sv
`timescale 1ns/1ps
// Field-set input, encoded-word output and status bundle of the RV32I instruction encoder.
interface rv32i_instr_encoder_if #(
  parameter int ADDR_W = 12
);
  logic              start_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [2:0]        fmt_i;
  logic [6:0]        opcode_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [2:0]        funct3_i;
  logic [6:0]        funct7_i;
  logic [31:0]       imm_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       instr_o;
  logic [ADDR_W-1:0] addr_o;
  logic              err_o;
  logic [15:0]       count_o;

  modport master (
    output start_i, in_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i,
           funct3_i, funct7_i, imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, addr_o, err_o, count_o
  );

  modport slave (
    input  start_i, in_valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i,
           funct3_i, funct7_i, imm_i, out_ready_i,
    output in_ready_o, out_valid_o, instr_o, addr_o, err_o, count_o
  );
endinterface

// File: rtl/rv32i_instr_encoder.sv
`timescale 1ns/1ps
// Packs decoded RV32I fields into a 32-bit word tagged with a sequential imem byte address.
// Latency 1 via one output register; in_ready_o drops only while that register is full and stalled.
module rv32i_instr_encoder #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic                  clk_i,
  input logic                  rst_i,
  rv32i_instr_encoder_if.slave bus
);
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [31:0]       imm;
  logic              is_shift;
  logic              sext12_ok;
  logic              sext13_ok;
  logic              sext21_ok;
  logic              imm_ok;
  logic              legal;
  logic              accept;
  logic              take;
  logic [31:0]       instr_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [15:0]       count_base;

  logic              out_valid_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic              err_q;
  logic [15:0]       count_q;

  assign imm       = bus.imm_i;
  assign is_shift  = (bus.opcode_i == 7'h13) && ((bus.funct3_i == 3'd1) || (bus.funct3_i == 3'd5));
  // Signed range checks: all bits above the top immediate bit must copy it.
  assign sext12_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign sext13_ok = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign sext21_ok = (imm[31:20] == '0) || (imm[31:20] == '1);

  always_comb begin
    instr_nx = '0;
    imm_ok   = 1'b0;
    case (bus.fmt_i)
      FMT_R: begin
        instr_nx = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, bus.opcode_i};
        imm_ok   = 1'b1;
      end
      FMT_I: begin
        if (is_shift) begin
          instr_nx = {bus.funct7_i, imm[4:0], bus.rs1_i, bus.funct3_i, bus.rd_i, bus.opcode_i};
          imm_ok   = (imm[31:5] == '0);
        end else begin
          instr_nx = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, bus.opcode_i};
          imm_ok   = sext12_ok;
        end
      end
      FMT_S: begin
        instr_nx = {imm[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, imm[4:0], bus.opcode_i};
        imm_ok   = sext12_ok;
      end
      FMT_B: begin
        instr_nx = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                    imm[4:1], imm[11], bus.opcode_i};
        imm_ok   = sext13_ok && !imm[0];
      end
      FMT_U: begin
        instr_nx = {imm[31:12], bus.rd_i, bus.opcode_i};
        imm_ok   = (imm[11:0] == '0);
      end
      FMT_J: begin
        instr_nx = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd_i, bus.opcode_i};
        imm_ok   = sext21_ok && !imm[0];
      end
      default: begin
        instr_nx = '0;
        imm_ok   = 1'b0;
      end
    endcase
  end

  assign legal      = imm_ok && (bus.opcode_i[1:0] == 2'b11);
  assign accept     = bus.in_valid_i && bus.in_ready_o;
  assign take       = accept && legal;
  // start_i takes effect for a set accepted in the same cycle.
  assign cur_addr   = bus.start_i ? BASE_ADDR : addr_cnt_q;
  assign count_base = bus.start_i ? 16'd0 : count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      addr_q      <= '0;
      addr_cnt_q  <= BASE_ADDR;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      if (take) begin
        out_valid_q <= 1'b1;
        instr_q     <= instr_nx;
        addr_q      <= cur_addr;
      end
      addr_cnt_q <= take ? cur_addr + ADDR_W'(4) : cur_addr;
      err_q      <= (err_q && !bus.start_i) || (accept && !legal);
      count_q    <= (take && (count_base != 16'hFFFF)) ? count_base + 16'd1 : count_base;
    end
  end

  assign bus.in_ready_o  = !out_valid_q || bus.out_ready_i;
  assign bus.out_valid_o = out_valid_q;
  assign bus.instr_o     = instr_q;
  assign bus.addr_o      = addr_q;
  assign bus.err_o       = err_q;
  assign bus.count_o     = count_q;
endmodule

// File: tb/tb_rv32i_instr_encoder.sv
`timescale 1ns/1ps
// Bench for rv32i_instr_encoder: known-encoding table, directed stall/reset/wrap/restart
// sequences, and a randomized run scored against an arithmetic reference model.
module tb_rv32i_instr_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_instr_encoder_if #(.ADDR_W(12)) bus ();
  rv32i_instr_encoder_if #(.ADDR_W(4))  busw ();

  rv32i_instr_encoder #(.ADDR_W(12), .BASE_ADDR(12'h000)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );
  rv32i_instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'h8)) dut_w (
    .clk_i(clk), .rst_i(rst), .bus(busw.slave)
  );

  typedef struct {
    string       name;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] instr;
  } vec_t;

  typedef struct {
    logic        legal;
    logic [31:0] instr;
  } res_t;

  typedef struct {
    logic [31:0] instr;
    logic [11:0] addr;
  } word_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, int fmt, int op, int rd, int rs1, int rs2,
                              int f3, int f7, logic [31:0] imm, bit legal, logic [31:0] instr);
    vec_t v;
    v.name = nm; v.fmt = 3'(fmt); v.op = 7'(op); v.rd = 5'(rd); v.rs1 = 5'(rs1);
    v.rs2 = 5'(rs2); v.f3 = 3'(f3); v.f7 = 7'(f7); v.imm = imm; v.legal = legal; v.instr = instr;
    return v;
  endfunction

  // Reference encoder: signed ranges and shifted/masked bit fields.
  function automatic res_t model(vec_t v);
    res_t        r;
    logic [31:0] u = v.imm;
    int          s = $signed(v.imm);
    logic [31:0] regs_src = (32'(v.rs2) << 20) | (32'(v.rs1) << 15) | (32'(v.f3) << 12);
    logic [31:0] low = (32'(v.rd) << 7) | 32'(v.op);
    r.legal = 1'b0;
    r.instr = '0;
    case (v.fmt)
      3'd0: begin r.legal = 1; r.instr = (32'(v.f7) << 25) | regs_src | low; end
      3'd1: begin
        if (v.op == 7'h13 && (v.f3 == 3'd1 || v.f3 == 3'd5)) begin
          r.legal = (u < 32);
          r.instr = (32'(v.f7) << 25) | ((u & 32'h1F) << 20) | (32'(v.rs1) << 15) | (32'(v.f3) << 12) | low;
        end else begin
          r.legal = (s >= -2048) && (s <= 2047);
          r.instr = ((u & 32'hFFF) << 20) | (32'(v.rs1) << 15) | (32'(v.f3) << 12) | low;
        end
      end
      3'd2: begin
        r.legal = (s >= -2048) && (s <= 2047);
        r.instr = (((u >> 5) & 32'h7F) << 25) | regs_src | ((u & 32'h1F) << 7) | 32'(v.op);
      end
      3'd3: begin
        r.legal = (s >= -4096) && (s <= 4095) && (u % 2 == 0);
        r.instr = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | regs_src |
                  (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'(v.op);
      end
      3'd4: begin
        r.legal = (u % 4096 == 0);
        r.instr = (u & 32'hFFFFF000) | low;
      end
      3'd5: begin
        r.legal = (s >= -1048576) && (s <= 1048575) && (u % 2 == 0);
        r.instr = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                  (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | low;
      end
      default: r.legal = 1'b0;
    endcase
    if (v.op % 4 != 3) r.legal = 1'b0;
    return r;
  endfunction

  task automatic drive_main(vec_t v, bit vld);
    bus.in_valid_i = vld; bus.fmt_i = v.fmt; bus.opcode_i = v.op; bus.rd_i = v.rd;
    bus.rs1_i = v.rs1; bus.rs2_i = v.rs2; bus.funct3_i = v.f3; bus.funct7_i = v.f7; bus.imm_i = v.imm;
  endtask

  task automatic drive_w(vec_t v, bit vld);
    busw.in_valid_i = vld; busw.fmt_i = v.fmt; busw.opcode_i = v.op; busw.rd_i = v.rd;
    busw.rs1_i = v.rs1; busw.rs2_i = v.rs2; busw.funct3_i = v.f3; busw.funct7_i = v.f7; busw.imm_i = v.imm;
  endtask

  // Scoreboard on the 12-bit instance, evaluated for the upcoming rising edge.
  word_t       q[$];
  logic [11:0] m_addr;
  logic        m_err;
  logic [15:0] m_count;
  bit          mon_on = 0;
  bit          m_rdy;
  vec_t        m_cur;
  res_t        m_res;

  always @(negedge clk) begin
    if (mon_on) begin
      chk("mon_valid", 64'(bus.out_valid_o), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("mon_instr", 64'(bus.instr_o), 64'(q[0].instr));
        chk("mon_addr",  64'(bus.addr_o),  64'(q[0].addr));
      end
      chk("mon_ready", 64'(bus.in_ready_o), 64'((q.size() == 0) || bus.out_ready_i));
      chk("mon_err",   64'(bus.err_o),      64'(m_err));
      chk("mon_count", 64'(bus.count_o),    64'(m_count));
    end
    if (rst) begin
      q.delete(); m_addr = '0; m_err = 0; m_count = '0; mon_on = 1;
    end else if (mon_on) begin
      m_rdy = (q.size() == 0) || bus.out_ready_i;
      if (q.size() != 0 && bus.out_ready_i) void'(q.pop_front());
      if (bus.start_i) begin m_addr = '0; m_err = 0; m_count = '0; end
      if (bus.in_valid_i && m_rdy) begin
        m_cur = mk("mon", int'(bus.fmt_i), int'(bus.opcode_i), int'(bus.rd_i), int'(bus.rs1_i),
                   int'(bus.rs2_i), int'(bus.funct3_i), int'(bus.funct7_i), bus.imm_i, 0, '0);
        m_res = model(m_cur);
        if (m_res.legal) begin
          q.push_back('{instr: m_res.instr, addr: m_addr});
          m_addr = m_addr + 12'd4;
          if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  vec_t        tbl[$];
  vec_t        va, vb, vc, rv;
  logic [11:0] exp_addr;
  logic [15:0] exp_cnt;
  logic        exp_err;
  logic [3:0]  wexp[5];
  logic [31:0] ri;

  initial begin
    rst = 1'b1;
    bus.start_i = 0; bus.out_ready_i = 0; busw.start_i = 0; busw.out_ready_i = 0;
    drive_main(mk("idle", 0, 0, 0, 0, 0, 0, 0, '0, 0, '0), 0);
    drive_w(mk("idle", 0, 0, 0, 0, 0, 0, 0, '0, 0, '0), 0);

    tbl.push_back(mk("addi_5",     1, 'h13, 1, 0, 0, 0, 0,    32'd5,         1, 32'h00500093));
    tbl.push_back(mk("sw_8",       2, 'h23, 0, 1, 2, 2, 0,    32'd8,         1, 32'h0020A423));
    tbl.push_back(mk("add",        0, 'h33, 3, 1, 2, 0, 0,    32'hDEADBEEF,  1, 32'h002081B3));
    tbl.push_back(mk("sub",        0, 'h33, 3, 1, 2, 0, 'h20, 32'h0,         1, 32'h402081B3));
    tbl.push_back(mk("beq_m4",     3, 'h63, 0, 0, 0, 0, 0,    32'hFFFFFFFC,  1, 32'hFE000EE3));
    tbl.push_back(mk("jal_2048",   5, 'h6F, 1, 0, 0, 0, 0,    32'd2048,      1, 32'h001000EF));
    tbl.push_back(mk("lui",        4, 'h37, 5, 0, 0, 0, 0,    32'h12345000,  1, 32'h123452B7));
    tbl.push_back(mk("srai_7",     1, 'h13, 3, 3, 0, 5, 'h20, 32'd7,         1, 32'h4071D193));
    tbl.push_back(mk("addi_m2048", 1, 'h13, 1, 0, 0, 0, 0,    32'hFFFFF800,  1, 32'h80000093));
    tbl.push_back(mk("addi_2047",  1, 'h13, 1, 0, 0, 0, 0,    32'd2047,      1, 32'h7FF00093));
    tbl.push_back(mk("beq_4094",   3, 'h63, 0, 0, 0, 0, 0,    32'd4094,      1, 32'h7E000FE3));
    tbl.push_back(mk("jal_m2",     5, 'h6F, 0, 0, 0, 0, 0,    32'hFFFFFFFE,  1, 32'hFFFFF06F));
    tbl.push_back(mk("rej_addi",   1, 'h13, 1, 0, 0, 0, 0,    32'd2048,      0, 32'h0));
    tbl.push_back(mk("rej_jal_odd",5, 'h6F, 1, 0, 0, 0, 0,    32'd3,         0, 32'h0));
    tbl.push_back(mk("rej_fmt6",   6, 'h33, 1, 0, 0, 0, 0,    32'd0,         0, 32'h0));
    tbl.push_back(mk("rej_opc",    0, 'h10, 1, 2, 3, 0, 0,    32'd0,         0, 32'h0));
    tbl.push_back(mk("rej_lui",    4, 'h37, 5, 0, 0, 0, 0,    32'h12345001,  0, 32'h0));
    tbl.push_back(mk("rej_beq_odd",3, 'h63, 0, 0, 0, 0, 0,    32'd1,         0, 32'h0));
    tbl.push_back(mk("rej_slli32", 1, 'h13, 1, 1, 0, 1, 0,    32'd32,        0, 32'h0));
    tbl.push_back(mk("addi_after", 1, 'h13, 1, 0, 0, 0, 0,    32'd5,         1, 32'h00500093));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 64'(bus.out_valid_o), 64'(0));
    chk("rst_instr", 64'(bus.instr_o),     64'(0));
    chk("rst_addr",  64'(bus.addr_o),      64'(0));
    chk("rst_err",   64'(bus.err_o),       64'(0));
    chk("rst_count", 64'(bus.count_o),     64'(0));
    chk("rst_ready", 64'(bus.in_ready_o),  64'(1));

    // Back-to-back table, one set per cycle.
    exp_addr = '0; exp_cnt = '0; exp_err = 0;
    bus.out_ready_i = 1;
    foreach (tbl[i]) begin
      drive_main(tbl[i], 1);
      @(posedge clk); #1;
      if (tbl[i].legal) begin
        chk({tbl[i].name, "_valid"}, 64'(bus.out_valid_o), 64'(1));
        chk(tbl[i].name,             64'(bus.instr_o),     64'(tbl[i].instr));
        chk({tbl[i].name, "_addr"},  64'(bus.addr_o),      64'(exp_addr));
        exp_addr = exp_addr + 12'd4;
        exp_cnt  = exp_cnt + 16'd1;
      end else begin
        chk({tbl[i].name, "_valid"}, 64'(bus.out_valid_o), 64'(0));
        exp_err = 1;
      end
      chk({tbl[i].name, "_err"},   64'(bus.err_o),   64'(exp_err));
      chk({tbl[i].name, "_count"}, 64'(bus.count_o), 64'(exp_cnt));
    end
    bus.in_valid_i = 0;
    @(posedge clk); #1;
    chk("drain_valid", 64'(bus.out_valid_o), 64'(0));

    // Backpressure: A held three cycles, B accepted on the release edge.
    va = mk("bp_a", 1, 'h13, 2, 0, 0, 0, 0, 32'd1, 1, 32'h00100113);
    vb = mk("bp_b", 1, 'h13, 3, 0, 0, 0, 0, 32'd2, 1, 32'h00200193);
    bus.out_ready_i = 0;
    drive_main(va, 1);
    @(posedge clk); #1;
    drive_main(vb, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_ready", 64'(bus.in_ready_o), 64'(0));
      chk("bp_hold_instr", 64'(bus.instr_o), 64'(va.instr));
      chk("bp_hold_addr",  64'(bus.addr_o),  64'(exp_addr));
    end
    bus.out_ready_i = 1;
    @(posedge clk); #1;
    chk("bp_b_valid", 64'(bus.out_valid_o), 64'(1));
    chk("bp_b_instr", 64'(bus.instr_o),     64'(vb.instr));
    chk("bp_b_addr",  64'(bus.addr_o),      64'(exp_addr + 12'd4));
    chk("bp_count",   64'(bus.count_o),     64'(exp_cnt + 16'd2));

    // Reset while stalled with B pending.
    vc = mk("rs_c", 1, 'h13, 4, 0, 0, 0, 0, 32'd3, 1, 32'h00300213);
    bus.out_ready_i = 0;
    drive_main(vc, 1);
    @(posedge clk); #1;
    chk("rs_stall_instr", 64'(bus.instr_o), 64'(vb.instr));
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rs_valid", 64'(bus.out_valid_o), 64'(0));
    chk("rs_count", 64'(bus.count_o),     64'(0));
    chk("rs_err",   64'(bus.err_o),       64'(0));
    chk("rs_ready", 64'(bus.in_ready_o),  64'(1));
    @(posedge clk); #1;
    chk("rs_c_valid", 64'(bus.out_valid_o), 64'(1));
    chk("rs_c_instr", 64'(bus.instr_o),     64'(vc.instr));
    chk("rs_c_addr",  64'(bus.addr_o),      64'(0));
    bus.in_valid_i = 0; bus.out_ready_i = 1;
    @(posedge clk); #1;

    // 4-bit address instance with base 8: wrap, reject, restart.
    wexp = '{4'd8, 4'd12, 4'd0, 4'd4, 4'd8};
    busw.out_ready_i = 1;
    for (int k = 0; k < 5; k++) begin
      drive_w(mk("w", 1, 'h13, k + 1, 0, 0, 0, 0, 32'(k), 1, '0), 1);
      @(posedge clk); #1;
      chk("wrap_addr",  64'(busw.addr_o),  64'(wexp[k]));
      chk("wrap_count", 64'(busw.count_o), 64'(k + 1));
    end
    drive_w(mk("wrej", 5, 'h6F, 1, 0, 0, 0, 0, 32'd3, 0, '0), 1);
    @(posedge clk); #1;
    chk("wrej_err",   64'(busw.err_o),       64'(1));
    chk("wrej_valid", 64'(busw.out_valid_o), 64'(0));
    chk("wrej_count", 64'(busw.count_o),     64'(5));
    busw.in_valid_i = 0; busw.start_i = 1;
    @(posedge clk); #1;
    busw.start_i = 0;
    chk("start_err",   64'(busw.err_o),   64'(0));
    chk("start_count", 64'(busw.count_o), 64'(0));
    drive_w(mk("w", 1, 'h13, 7, 0, 0, 0, 0, 32'd9, 1, '0), 1);
    @(posedge clk); #1;
    busw.in_valid_i = 0;
    chk("start_addr",       64'(busw.addr_o),  64'(8));
    chk("start_next_count", 64'(busw.count_o), 64'(1));

    // Randomized traffic on the 12-bit instance.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 299) == 0);
      bus.start_i = ($urandom_range(0, 63) == 0);
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      ri = $urandom;
      case ($urandom_range(0, 5))
        0: ri = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: ri = 32'($urandom_range(0, 63));
        2: ri = ri & 32'hFFFFF000;
        3: ri = 32'($urandom_range(0, 8191)) - 32'd4096;
        4: ri = {{11{ri[20]}}, ri[20:0]};
        default: ;
      endcase
      rv = mk("rnd", int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 127)), ri, 0, '0);
      case ($urandom_range(0, 9))
        0: rv.op = 7'h33; 1: rv.op = 7'h13; 2: rv.op = 7'h03; 3: rv.op = 7'h23;
        4: rv.op = 7'h63; 5: rv.op = 7'h37; 6: rv.op = 7'h17; 7: rv.op = 7'h6F;
        8: rv.op = 7'h67;
        default: ;
      endcase
      drive_main(rv, $urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst = 0; bus.start_i = 0; bus.in_valid_i = 0; bus.out_ready_i = 1;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
